quadra_sched: RTL

- Round-robin scheduler that shares one quadra evaluator pipeline (fixed 3-cycle latency, no valid/stall) among N_REQ requesters.
- Accepts at most one request per cycle through valid/ready handshakes and drives the evaluator input.
- Tracks in-flight operations in a tag pipeline aligned to the evaluator latency, and steers each result back to its originator.
- Enforces a per-requester outstanding-operation limit.

---
 rtl/quadra_sched_pkg.sv | 18 +
 rtl/quadra_sched_rr_arbiter.sv | 30 +++
 rtl/quadra_sched.sv | 129 ++++++++++++
 3 files changed

// File: rtl/quadra_sched_pkg.sv
// Shared types for the quadra evaluator and its scheduler: operand/result
// widths, the evaluator latency and the in-flight tag record.
package quadra_sched_pkg;

    typedef logic [23:0] x_t;
    typedef logic [24:0] y_t;

    localparam int QUADRA_LATENCY = 3;

    // Tag ids are stored wide enough for up to 256 requesters.
    localparam int TAG_ID_W = 8;

    typedef struct packed {
        logic                vld;
        logic [TAG_ID_W-1:0] id;
    } tag_t;

endpackage

// File: rtl/quadra_sched_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first eligible index at or after
// ptr, wrapping N-1 -> 0. Purely combinational.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  elig,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx
);

    always_comb begin
        int   idx;
        logic found;
        idx       = 0;
        found     = 1'b0;
        grant     = '0;
        grant_idx = '0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!found && elig[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/quadra_sched.sv
// Round-robin scheduler sharing one fixed-latency quadra evaluator among
// N_REQ requesters, with a tag pipe that steers results back to their origin.
module quadra_sched
    import quadra_sched_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int LATENCY   = QUADRA_LATENCY,
    parameter int MAX_OUTST = 2
) (
    input  logic                clk,
    input  logic                rst_b,
    input  logic [N_REQ-1:0]    req_valid,
    input  logic [N_REQ*24-1:0] req_x,
    output logic [N_REQ-1:0]    req_ready,
    output x_t                  q_x,
    input  y_t                  q_y,
    output logic [N_REQ-1:0]    rsp_valid,
    output y_t                  rsp_y,
    output logic                busy
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = $clog2(MAX_OUTST + 1);

    logic [IW-1:0]    ptr_q, ptr_d;
    tag_t             tag_q [LATENCY];
    logic [CW-1:0]    outst_q [N_REQ];
    logic [CW-1:0]    outst_d [N_REQ];
    logic [N_REQ-1:0] elig;
    logic [N_REQ-1:0] grant;
    logic [IW-1:0]    grant_idx;
    logic             transfer;
    tag_t             tail;

    always_comb begin
        elig = '0;
        for (int i = 0; i < N_REQ; i++) begin
            elig[i] = req_valid[i] && (outst_q[i] < CW'(MAX_OUTST));
        end
    end

    rr_arbiter #(.N(N_REQ), .IW(IW)) u_arb (
        .elig      (elig),
        .ptr       (ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // Handshake: a transfer happens in a cycle where req_valid[i] & req_ready[i];
    // ready is the one-hot grant and may depend combinationally on req_valid.
    assign transfer  = rst_b && (|grant);
    assign req_ready = rst_b ? grant : '0;

    always_comb begin
        q_x = '0;
        if (transfer) begin
            q_x = req_x[int'(grant_idx)*24 +: 24];
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (transfer) begin
            ptr_d = (int'(grant_idx) == N_REQ - 1) ? '0 : grant_idx + IW'(1);
        end
    end

    assign tail  = tag_q[LATENCY-1];
    assign rsp_y = q_y;

    always_comb begin
        rsp_valid = '0;
        for (int i = 0; i < N_REQ; i++) begin
            rsp_valid[i] = rst_b && tail.vld && (tail.id == TAG_ID_W'(i));
        end
    end

    always_comb begin
        busy = 1'b0;
        for (int k = 0; k < LATENCY; k++) begin
            busy = busy | tag_q[k].vld;
        end
        busy = busy && rst_b;
    end

    // Issue and retire in the same cycle cancel; eligibility used the pre-update count.
    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            outst_d[i] = outst_q[i];
            if (transfer && grant[i] && !rsp_valid[i]) begin
                outst_d[i] = outst_q[i] + CW'(1);
            end else if (!(transfer && grant[i]) && rsp_valid[i]) begin
                outst_d[i] = outst_q[i] - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            ptr_q <= '0;
            for (int k = 0; k < LATENCY; k++) begin
                tag_q[k] <= '0;
            end
            for (int i = 0; i < N_REQ; i++) begin
                outst_q[i] <= '0;
            end
        end else begin
            ptr_q        <= ptr_d;
            tag_q[0].vld <= transfer;
            tag_q[0].id  <= TAG_ID_W'(grant_idx);
            for (int k = 1; k < LATENCY; k++) begin
                tag_q[k] <= tag_q[k-1];
            end
            for (int i = 0; i < N_REQ; i++) begin
                outst_q[i] <= outst_d[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_b) begin
            for (int i = 0; i < N_REQ; i++) begin
                assert (outst_q[i] <= CW'(MAX_OUTST));
                assert (!(rsp_valid[i] && (outst_q[i] == '0)));
            end
        end
    end

endmodule
